// File: rtl/ring_token_arbiter_pkg.sv
// Shared types and one-hot helpers for the ring token arbiter.
// Helpers work on MAX_N-wide vectors; callers zero-extend their N-bit values.
package ring_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_N = 32;
    localparam int IDX_W = 5;

    // Rotate an n-bit one-hot vector left by one, bit n-1 wrapping to bit 0.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N - 1; i++) begin
            if (i + 1 < n) r[i+1] = v[i];
        end
        for (int i = 0; i < MAX_N; i++) begin
            if (i == n - 1) r[0] = v[i];
        end
        return r;
    endfunction

    function automatic logic onehot_chk(input logic [MAX_N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_N; i++) begin
            c += int'(v[i]);
        end
        return (c == 1);
    endfunction

    function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_token_arbiter_if.sv
// Request/grant bundle between the requesters and the ring token arbiter.
// Handshake: req is a level held by a requester; gnt (one-hot) is the arbiter's registered answer.
interface ring_token_arbiter_if #(
    parameter int N = 4
);
    import ring_arb_pkg::*;

    logic                 load;
    logic [N-1:0]         load_sel;
    logic [N-1:0]         req;
    logic [N-1:0]         gnt;
    logic                 gnt_valid;
    logic [$clog2(N)-1:0] gnt_id;
    logic [N-1:0]         token;
    state_t               dbg_state;

    modport master (
        output load, load_sel, req,
        input  gnt, gnt_valid, gnt_id, token, dbg_state
    );

    modport slave (
        input  load, load_sel, req,
        output gnt, gnt_valid, gnt_id, token, dbg_state
    );

endinterface

// File: rtl/ring_token_arbiter_rr_pick.sv
// Circular priority picker: first set req bit at or above the token, wrapping.
// The request vector is doubled so the wrap becomes a plain lowest-bit isolate.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] token,
    output logic [N-1:0] pick,
    output logic         any
);
    localparam int W2 = 2 * N;

    logic [N-1:0]  tok_mask;
    logic [W2-1:0] dbl;
    logic [W2-1:0] iso;

    always_comb begin
        // Lower copy keeps only bits at/above the token; upper copy covers the wrap.
        tok_mask = ~(token - N'(1));
        dbl      = {req, req & tok_mask};
        iso      = dbl & ~(dbl - W2'(1));
        pick     = iso[N-1:0] | iso[W2-1:N];
        any      = |req;
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and bounded tenure.
// All outputs are registered; the token moves only on release, load or reset.
module ring_token_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ring_token_arbiter_if.slave       bus
);
    localparam int IW = $clog2(N);

    state_t             state_q, state_nx;
    logic [N-1:0]       token_q, token_nx;
    logic [N-1:0]       gnt_q, gnt_nx;
    logic               gnt_valid_q;
    logic [IW-1:0]      gnt_id_q;
    logic [HOLD_W-1:0]  hold_q, hold_nx;
    logic [N-1:0]       pick;
    logic               pick_any;
    logic               release_now;

    rr_pick #(.N(N)) u_pick (
        .req   (bus.req),
        .token (token_q),
        .pick  (pick),
        .any   (pick_any)
    );

    // Tenure ends when the owner drops its request or has used its full budget.
    assign release_now = (state_q == GRANT) &&
                         (((bus.req & gnt_q) == '0) || (hold_q == HOLD_W'(MAX_HOLD)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            token_q     <= N'(1);
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_nx;
            token_q     <= token_nx;
            gnt_q       <= gnt_nx;
            gnt_valid_q <= |gnt_nx;
            gnt_id_q    <= IW'(oh2idx(MAX_N'(gnt_nx)));
            hold_q      <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        if (bus.load) begin
            state_nx = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (pick_any) state_nx = GRANT;
                GRANT:   if (release_now) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        token_nx = token_q;
        gnt_nx   = gnt_q;
        hold_nx  = hold_q;
        if (bus.load) begin
            gnt_nx  = '0;
            hold_nx = '0;
            // Zero or multi-hot seeds would corrupt the ring, so they are dropped.
            if (onehot_chk(MAX_N'(bus.load_sel))) token_nx = bus.load_sel;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gnt_nx  = pick;
                        hold_nx = HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_nx   = '0;
                        hold_nx  = '0;
                        token_nx = N'(rotl1(MAX_N'(gnt_q), N));
                    end else begin
                        hold_nx = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    gnt_nx  = '0;
                    hold_nx = '0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.token     = token_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Bench for ring_token_arbiter: directed plan plus random traffic against an
// index-based reference model of the round-robin rules.
module tb_ring_token_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // Reference model: token index, owner index (-1 = none), tenure count.
    int m_tok;
    int m_own;
    int m_cnt;

    ring_token_arbiter_if #(.N(N)) bus ();

    ring_token_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic ld, input logic [N-1:0] ls,
                              input logic rs);
        int ones;
        int idx;
        if (rs) begin
            m_tok = 0;
            m_own = -1;
            m_cnt = 0;
        end else if (ld) begin
            m_own = -1;
            m_cnt = 0;
            ones  = 0;
            idx   = 0;
            for (int i = 0; i < N; i++) if (ls[i]) begin ones++; idx = i; end
            if (ones == 1) m_tok = idx;
        end else if (m_own < 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_own < 0 && r[(m_tok + i) % N]) begin
                    m_own = (m_tok + i) % N;
                    m_cnt = 1;
                end
            end
        end else if (!r[m_own] || m_cnt == MAX_HOLD) begin
            m_tok = (m_own + 1) % N;
            m_own = -1;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare 1 time unit after the edge.
    task automatic cycle(input logic [N-1:0] r, input logic ld, input logic [N-1:0] ls,
                         input logic rs);
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_tok;
        bus.req      = r;
        bus.load     = ld;
        bus.load_sel = ls;
        rst          = rs;
        @(posedge clk);
        model_step(r, ld, ls, rs);
        #1;
        exp_gnt = (m_own < 0) ? '0 : N'(1 << m_own);
        exp_tok = N'(1 << m_tok);
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("gnt_valid", 32'(bus.gnt_valid), 32'(m_own >= 0));
        check("gnt_id", 32'(bus.gnt_id), (m_own < 0) ? 32'd0 : 32'(m_own));
        check("token", 32'(bus.token), 32'(exp_tok));
    endtask

    task automatic do_reset();
        cycle('0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] ls;
        logic         ld;
        logic         rs;
        n_cmp = 0;
        n_err = 0;
        m_tok = 0;
        m_own = -1;
        m_cnt = 0;
        bus.req = '0;
        bus.load = 1'b0;
        bus.load_sel = '0;
        rst = 1'b1;

        // Reset values
        do_reset();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_token", 32'(bus.token), 32'd1);
        check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);

        // All requesting: 3-cycle tenures with one idle bubble, token walks the ring
        for (int k = 1; k <= 17; k++) begin
            cycle(4'b1111, 1'b0, '0, 1'b0);
            if (k == 1)  check("s1_first", 32'(bus.gnt), 32'b0001);
            if (k == 4)  check("s1_bubble", 32'(bus.gnt), 32'b0000);
            if (k == 5)  check("s1_second", 32'(bus.gnt), 32'b0010);
            if (k == 13) check("s1_tok3", 32'(bus.token), 32'b1000);
            if (k == 17) check("s1_wrap", 32'(bus.gnt), 32'b0001);
        end

        // Single-cycle request drop
        do_reset();
        cycle(4'b0100, 1'b0, '0, 1'b0);
        check("s2_gnt", 32'(bus.gnt), 32'b0100);
        cycle(4'b0000, 1'b0, '0, 1'b0);
        check("s2_drop", 32'(bus.gnt), 32'b0000);
        check("s2_tok", 32'(bus.token), 32'b1000);

        // Wrap from token 0100 to lower requesters
        do_reset();
        cycle(4'b0000, 1'b1, 4'b0100, 1'b0);
        cycle(4'b0011, 1'b0, '0, 1'b0);
        check("s3_wrap", 32'(bus.gnt), 32'b0001);
        for (int k = 0; k < 4; k++) cycle(4'b0011, 1'b0, '0, 1'b0);
        check("s3_next", 32'(bus.gnt), 32'b0010);

        // Load during requester 1's tenure
        do_reset();
        cycle(4'b0000, 1'b1, 4'b0010, 1'b0);
        cycle(4'b1010, 1'b0, '0, 1'b0);
        check("s4_own1", 32'(bus.gnt), 32'b0010);
        cycle(4'b1010, 1'b1, 4'b1000, 1'b0);
        check("s4_abort", 32'(bus.gnt), 32'b0000);
        check("s4_tok", 32'(bus.token), 32'b1000);
        cycle(4'b1010, 1'b0, '0, 1'b0);
        check("s4_regrant", 32'(bus.gnt), 32'b1000);

        // Multi-hot seed ignored, grant still cleared
        cycle(4'b1010, 1'b1, 4'b0110, 1'b0);
        check("s5_gnt", 32'(bus.gnt), 32'b0000);
        check("s5_tok", 32'(bus.token), 32'b1000);

        // Reset on the second cycle of a tenure
        cycle(4'b0110, 1'b0, '0, 1'b0);
        cycle(4'b0110, 1'b0, '0, 1'b0);
        cycle(4'b0110, 1'b0, '0, 1'b1);
        check("s6_gnt", 32'(bus.gnt), 32'b0000);
        check("s6_id", 32'(bus.gnt_id), 32'd0);
        check("s6_tok", 32'(bus.token), 32'b0001);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            r  = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            ld = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 1);
            ls = ($urandom_range(0, 1) == 1) ? N'(1 << $urandom_range(0, N - 1))
                                             : N'($urandom_range(0, 15));
            cycle(r, ld, ls, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ring_token_arbiter.md
# ring_token_arbiter

Round-robin arbiter that shares one resource among `N` requesters using a rotating one-hot priority token, the same token-rotation principle as the team's ring counter. It grants one requester at a time, bounds each tenure to `MAX_HOLD` cycles and advances the token past the last owner. It supports a `load` override that seeds the token position. It sits in front of any shared datapath resource and drives that resource's select/enable.

## Interface
- `N`, 4, number of requesters (≥2)
- `MAX_HOLD`, 8, maximum consecutive grant cycles per tenure (1..2^HOLD_W-1)
- `HOLD_W`, 4, width of hold counter
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: reset, synchronous and active-high
- `load` in 1: force token to `load_sel` and abort any grant
- `load_sel` in N: one-hot token seed, sampled when `load`=1
- `req` in N: level request per requester
- `gnt` out N: one-hot grant, or all-zero
- `gnt_valid` out 1: OR of `gnt`
- `gnt_id` out $clog2(N): index of granted requester; 0 when `gnt_valid`=0
- `token` out N: current one-hot priority position

## Operation
- States: IDLE, GRANT. Priority of events each edge: `rst` > `load` > normal FSM.
- Reset values: `token`=1 (bit 0), `gnt`=0, `gnt_valid`=0, `gnt_id`=0, hold counter=0, state IDLE.
- `load`=1 (not in reset): `gnt`←0 and state←IDLE.
  - If `load_sel` is exactly one-hot, `token`←`load_sel`.
  - Otherwise `token` is unchanged (zero or multi-hot seeds are ignored).
- IDLE, any `req` bit set, no load: pick the first set `req` bit scanning circularly from the `token` position upward (token bit included), with wrap MSB→bit 0. `gnt`←that bit, hold←1, state←GRANT.
- IDLE, `req`=0: remain IDLE; `token` unchanged.
- GRANT: release when `req[owner]`=0 or hold==`MAX_HOLD`. On release:
  - `gnt`←0, state←IDLE.
  - `token`←owner rotated left by 1 (owner N-1 wraps to bit 0).
- GRANT, no release: hold←hold+1; `gnt` unchanged. Requests from other requesters never preempt.
- `token` changes only on release, `load` or `rst`.
- `gnt` is never multi-hot; `gnt_id` is consistent with `gnt` in the same cycle.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Grant latency: `req` sampled high in IDLE at edge k gives `gnt` high from edge k onward (visible the cycle after the request is presented).
- Tenure length: at most `MAX_HOLD` cycles of `gnt` high. Release takes effect at the edge where the condition is sampled.
- One mandatory IDLE bubble cycle between consecutive tenures, including back-to-back grants to different requesters.
- Requester dropping `req` while granted: `gnt` falls at the next edge (one cycle of `gnt` with `req` low is legal).
- `load` mid-tenure: `gnt` falls at that edge; the next grant is arbitrated from the new token one cycle later at the earliest.
- `rst` mid-tenure: all outputs at reset values after that edge.

## Structure
- Package `ring_arb_pkg`:
  - state enum (IDLE, GRANT)
  - function `rotl1` (one-hot rotate-left with wrap)
  - function `onehot_chk` (exactly-one-bit test)
  - function `oh2idx` (one-hot to index)
- Sub-module `rr_pick`: combinational circular priority picker; inputs `req`, `token`; outputs one-hot `pick` and `any`. Implemented via double-width masked priority encode.
- Top: FSM, hold counter, token register, output registers.

## Test plan
All scenarios use `N`=4, `MAX_HOLD`=3.
- Reset then `req`=4'b1111 held → grants to 0,1,2,3,0, each 3 cycles with 1 idle cycle between; `token` 0001→0010→0100→1000→0001.
- From reset, `req`=4'b0100 for 1 cycle then low → `gnt`=0100 for 1 cycle, then `token`=1000, `gnt`=0.
- `token`=0100, `req`=4'b0011 → grant 0001 first (wrap), then 0010.
- `load`=1, `load_sel`=1000 during a tenure of requester 1 → `gnt`=0 next edge, `token`=1000. With `req`=4'b1010 the next grant is 1000.
- `load_sel`=0110 with `load`=1 → `token` unchanged, `gnt` cleared.
- `rst` asserted on the 2nd cycle of a tenure → `gnt`=0, `gnt_id`=0, `token`=0001 after that edge.
